uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001: Parameter OVERSAMPLE, default 16: baud_tick_16x pulses per bit period; legal values are even and at least 8.
REQ-002: clk  input  1  single clock; all state changes on rising edge.
REQ-003: resetn  input  1  asynchronous, active-low reset.
REQ-004: baud_tick_16x  input  1  one-clk-wide strobe at OVERSAMPLE x baud rate.
REQ-005: rx_pin  input  1  asynchronous serial line; idles high.
REQ-006: parity_enable  input  1  1 = frame carries an even-parity bit after the data bits; sampled at start-bit confirmation.
REQ-007: rx_data  output  8  last received byte, reassembled LSB first.
REQ-008: rx_valid  output  1  one-clk pulse marking a completed frame.
REQ-009: parity_error  output  1  parity mismatch on the frame flagged by the last rx_valid.
REQ-010: frame_error  output  1  stop bit sampled low on the frame flagged by the last rx_valid.
REQ-011: rx_busy  output  1  high in any state other than IDLE.

Function
REQ-012: rx_pin SHALL pass through a 2-flop synchronizer; all logic SHALL use the synchronized value (rx_s).
REQ-013: The FSM SHALL have five states: IDLE, START, DATA, PARITY, STOP.
REQ-014: Oversample counter:
  - advances only on baud_tick_16x;
  - clears on every state entry;
  - defines the mid-bit sample point as count OVERSAMPLE/2.
REQ-015: IDLE -> START on a high-to-low transition of rx_s; a line already held low SHALL NOT trigger.
REQ-016: START, at the mid-bit sample point:
  - rx_s high: false start, return to IDLE, no outputs change;
  - rx_s low: go to DATA and latch parity_enable.
REQ-017: DATA SHALL:
  - sample 8 bits, one per OVERSAMPLE ticks after start mid-point;
  - shift LSB first into an internal shift register;
  - then go to PARITY if latched parity is enabled, else STOP.
REQ-018: PARITY SHALL sample one bit and compute the error as (XOR of 8 data bits) XOR (sampled bit); nonzero = error.
REQ-019: STOP, at its mid-bit sample point, SHALL in the same cycle:
  - load rx_data from the shift register;
  - pulse rx_valid;
  - update parity_error (0 when parity disabled) and frame_error (1 when stop sample is 0);
  - go to IDLE.
REQ-020: Error flags SHALL hold until the next rx_valid; a frame with frame_error still delivers rx_data and rx_valid.
REQ-021: A new start edge SHALL be accepted from the cycle after STOP exits, so back-to-back frames with zero idle bits are received.
REQ-022: No output other than rx_busy SHALL change on false starts or aborted frames.

Reset
REQ-023: resetn low SHALL immediately force:
  - IDLE, counters and shift register to 0;
  - rx_data = 0x00, rx_valid = 0, parity_error = 0, frame_error = 0, rx_busy = 0;
  - both synchronizer flops to 1.
REQ-024: Reset asserted mid-frame SHALL discard the partial frame with no rx_valid; the first frame after release SHALL be received normally.

Configuration
REQ-025: Macro UART_RX_MAJORITY_VOTE_EN selects the bit-sampling method.
  - Defined: each bit value is the 2-of-3 majority of rx_s at counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1, decided at count OVERSAMPLE/2+1; all bit timing shifts one tick later.
  - Undefined: each bit value is the single rx_s sample at count OVERSAMPLE/2.

Verification
REQ-026: 0x55, parity off, stop high -> exactly one rx_valid; rx_data=0x55; parity_error=0; frame_error=0; rx_busy back to 0.
REQ-027: 0xA3, parity on:
  - parity bit 0 -> rx_data=0xA3, parity_error=0;
  - repeat with parity bit 1 -> parity_error=1.
REQ-028: 0x0F with stop bit driven 0, line held low for 3 bit times -> one rx_valid, rx_data=0x0F, frame_error=1, no further rx_valid until line returns high and a new start arrives.
REQ-029: rx_pin low for 4 ticks then high -> no rx_valid; rx_busy falls; next frame 0x3C received correctly.
REQ-030: resetn pulsed low during data bit 3 of 0xFF -> all outputs 0 immediately, no rx_valid; following frame 0x3C -> rx_data=0x3C.
REQ-031: Back-to-back 0x01 then 0x80 with no idle gap, plus a 1-tick high glitch at bit-2 mid-point of 0x80:
  - two rx_valid pulses;
  - second rx_data=0x80 with UART_RX_MAJORITY_VOTE_EN defined;
  - second rx_data=0x84 without it.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver, 8 data bits, optional even parity,
// one stop bit. The receive line passes through a 2-flop synchronizer and
// all framing decisions use the synchronized value.
//
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN
//   defined   - each bit is the 2-of-3 majority of the samples at the mid-bit
//               tick and its two neighbours, decided on the later neighbour.
//   undefined - each bit is the single sample at the mid-bit tick.
//
// Counter timing: in START the counter runs from the start edge, and the
// decision falls at count OVERSAMPLE/2 (one tick later with majority vote).
// In DATA, PARITY and STOP the counter restarts at every sample point, so
// each following sample lands exactly OVERSAMPLE ticks after the previous one
// and keeps the same offset into its bit.
//
// Debug: dbg_state exposes the FSM state register.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       baud_tick_16x,
    input  logic       rx_pin,
    input  logic       parity_enable,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_error,
    output logic       frame_error,
    output logic       rx_busy,
    output logic [2:0] dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] LAST_CNT = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 + 1);
`else
    localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2);
`endif

    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_cnt_q;
    logic [7:0]      shift_q;
    logic            par_en_q;
    logic            par_err_q;
    logic            rx_meta_q;
    logic            rx_s_q;
    logic            rx_prev_q;
    logic [7:0]      rx_data_q;
    logic            rx_valid_q;
    logic            parity_error_q;
    logic            frame_error_q;

    logic            bit_d;
    logic            fall_d;
    logic            start_pt_d;
    logic            bit_pt_d;

    // Synchronize the serial line and keep one extra stage for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_pin;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] hist_q;

    // Remember rx_s at the two previous ticks for the 2-of-3 vote
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_q <= 2'b11;
        end else if (baud_tick_16x) begin
            hist_q <= {hist_q[0], rx_s_q};
        end
    end

    assign bit_d = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
    assign bit_d = rx_s_q;
`endif

    assign fall_d     = rx_prev_q & ~rx_s_q;
    assign start_pt_d = baud_tick_16x && (cnt_q == START_PT);
    assign bit_pt_d   = baud_tick_16x && (cnt_q == LAST_CNT);

    // Receive FSM: counter, shift register and registered frame outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            bit_cnt_q      <= 3'd0;
            shift_q        <= 8'h00;
            par_en_q       <= 1'b0;
            par_err_q      <= 1'b0;
            rx_data_q      <= 8'h00;
            rx_valid_q     <= 1'b0;
            parity_error_q <= 1'b0;
            frame_error_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (fall_d) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (start_pt_d) begin
                        cnt_q <= '0;
                        if (bit_d) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            par_en_q  <= parity_enable;
                            bit_cnt_q <= 3'd0;
                        end
                    end else if (baud_tick_16x) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (bit_pt_d) begin
                        cnt_q     <= '0;
                        shift_q   <= {bit_d, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= par_en_q ? PARITY : STOP;
                        end
                    end else if (baud_tick_16x) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                PARITY: begin
                    if (bit_pt_d) begin
                        cnt_q     <= '0;
                        par_err_q <= (^shift_q) ^ bit_d;
                        state_q   <= STOP;
                    end else if (baud_tick_16x) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (bit_pt_d) begin
                        cnt_q          <= '0;
                        rx_data_q      <= shift_q;
                        rx_valid_q     <= 1'b1;
                        parity_error_q <= par_en_q & par_err_q;
                        frame_error_q  <= ~bit_d;
                        state_q        <= IDLE;
                    end else if (baud_tick_16x) begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign parity_error = parity_error_q;
    assign frame_error  = frame_error_q;
    assign rx_busy      = (state_q != IDLE);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx. Expected frames are queued as
// {frame_error, parity_error, data} when stimulus is issued; a monitor pops
// one entry on every rx_valid and compares.
// Baud tick: one clk wide, every 4 clocks. The serial line only changes just
// after a tick, so each bit spans exactly 16 ticks.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       baud_tick_16x = 1'b0;
  logic       rx_pin = 1'b1;
  logic       parity_enable = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       parity_error;
  logic       frame_error;
  logic       rx_busy;
  logic [2:0] dbg_state;

  logic [9:0] exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [7:0] GLITCH_EXP = 8'h80;
`else
  localparam logic [7:0] GLITCH_EXP = 8'h84;
`endif

  uart_rx #(.OVERSAMPLE(16)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .baud_tick_16x (baud_tick_16x),
    .rx_pin        (rx_pin),
    .parity_enable (parity_enable),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .parity_error  (parity_error),
    .frame_error   (frame_error),
    .rx_busy       (rx_busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- clock / tick / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      baud_tick_16x = 1'b1;
      @(negedge clk);
      baud_tick_16x = 1'b0;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (baud_tick_16x !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input logic v, input int n);
    rx_pin = v;
    wait_ticks(n);
  endtask

  // Send one frame; the line is left at the stop-bit level.
  // glitch_bit selects a data bit that is inverted for its 9th tick only.
  task automatic send_frame(input logic [7:0] d, input logic par_on, input logic par_bit,
                            input logic stop_bit, input int glitch_bit);
    parity_enable = par_on;
    drive(1'b0, 16);
    for (int i = 0; i < 8; i++) begin
      if (i == glitch_bit) begin
        drive(d[i], 8);
        drive(~d[i], 1);
        drive(d[i], 7);
      end else begin
        drive(d[i], 16);
      end
    end
    if (par_on) drive(par_bit, 16);
    drive(stop_bit, 16);
  endtask

  task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
    exp_q.push_back({ferr, perr, d});
  endtask

  task automatic drain(input string name);
    int budget = 2000;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d expected rx_valid pulse(s) missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    if (resetn && rx_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rx_valid: got rx_valid=1 with data 0x%02h, expected no pulse at %0t", rx_data, $time);
      end else begin
        e = exp_q.pop_front();
        check("rx_data", rx_data, e[7:0]);
        check("parity_error", {7'd0, parity_error}, {7'd0, e[8]});
        check("frame_error", {7'd0, frame_error}, {7'd0, e[9]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", {7'd0, rx_valid}, 8'h00);
    check("reset_parity_error", {7'd0, parity_error}, 8'h00);
    check("reset_frame_error", {7'd0, frame_error}, 8'h00);
    check("reset_rx_busy", {7'd0, rx_busy}, 8'h00);
    @(negedge clk);
    resetn = 1'b1;
    wait_ticks(20);

    // 0x55, parity off
    expect_frame(8'h55, 1'b0, 1'b0);
    send_frame(8'h55, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    drain("frame_55");
    check("busy_after_55", {7'd0, rx_busy}, 8'h00);

    // 0xA3, even parity: correct bit 0, then wrong bit 1
    expect_frame(8'hA3, 1'b0, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    drain("frame_a3_par0");
    expect_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1, 1'b1, 1'b1, -1);
    drive(1'b1, 16);
    drain("frame_a3_par1");
    check("parity_error_hold", {7'd0, parity_error}, 8'h01);

    // 0x0F with stop low, line held low for three more bit times
    expect_frame(8'h0F, 1'b0, 1'b1);
    send_frame(8'h0F, 1'b0, 1'b0, 1'b0, -1);
    drive(1'b0, 48);
    drain("frame_0f_stop0");
    check("frame_error_hold", {7'd0, frame_error}, 8'h01);
    check("busy_line_low", {7'd0, rx_busy}, 8'h00);
    drive(1'b1, 16);
    expect_frame(8'hC6, 1'b0, 1'b0);
    send_frame(8'hC6, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    drain("frame_c6");

    // False start: low for 4 ticks
    drive(1'b0, 2);
    check("busy_false_start", {7'd0, rx_busy}, 8'h01);
    drive(1'b0, 2);
    drive(1'b1, 12);
    check("busy_after_false_start", {7'd0, rx_busy}, 8'h00);
    check("data_after_false_start", rx_data, 8'hC6);
    drive(1'b1, 16);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    drain("frame_3c_after_false_start");

    // Reset during data bit 3 of 0xFF
    parity_enable = 1'b0;
    drive(1'b0, 16);
    drive(1'b1, 56);
    check("busy_mid_frame", {7'd0, rx_busy}, 8'h01);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_rx_data", rx_data, 8'h00);
    check("midreset_rx_valid", {7'd0, rx_valid}, 8'h00);
    check("midreset_parity_error", {7'd0, parity_error}, 8'h00);
    check("midreset_frame_error", {7'd0, frame_error}, 8'h00);
    check("midreset_rx_busy", {7'd0, rx_busy}, 8'h00);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    drive(1'b1, 88);
    expect_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, -1);
    drive(1'b1, 16);
    drain("frame_3c_after_reset");

    // Back-to-back 0x01 then 0x80, glitch on bit 2 of the second frame
    expect_frame(8'h01, 1'b0, 1'b0);
    expect_frame(GLITCH_EXP, 1'b0, 1'b0);
    send_frame(8'h01, 1'b0, 1'b0, 1'b1, -1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, 2);
    drive(1'b1, 16);
    drain("back_to_back");
    check("busy_end", {7'd0, rx_busy}, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
